// File: rtl/conv_out_streamer_pkg.sv
// Shared conv-output geometry and streamer state encoding.
package conv_out_streamer_pkg;
  localparam int CONV_DATA_W  = 8;
  localparam int CONV_OUT_H   = 6;
  localparam int CONV_OUT_W   = 6;
  localparam int CONV_OUT_C   = 3;
  localparam int CONV_FRAME_N = CONV_OUT_C * CONV_OUT_H * CONV_OUT_W;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} strm_state_e;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_out_streamer_if.sv
// Element stream from the conv result streamer to its consumer.
interface conv_out_streamer_if #(parameter int DATA_W = conv_out_streamer_pkg::CONV_DATA_W);
  logic [DATA_W-1:0] m_data;
  logic              m_vld;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, m_vld, m_last, input m_ready);
  modport slave  (input m_data, m_vld, m_last, output m_ready);
endinterface

// File: rtl/conv_out_streamer_mux.sv
// Combinational element select: idx -> one DATA_W element of the frame buffer.
module conv_stream_mux #(
  parameter int DATA_W  = 8,
  parameter int FRAME_N = 108,
  parameter int IDX_W   = 7
) (
  input  logic [FRAME_N-1:0][DATA_W-1:0] frame,
  input  logic [IDX_W-1:0]               idx,
  output logic [DATA_W-1:0]              data
);
  always_comb begin
    data = '0;
    if (int'(idx) < FRAME_N) data = frame[idx];
  end
endmodule

// File: rtl/conv_out_streamer.sv
// Captures a whole conv result frame and replays it element by element
// (channel, row, column order) over a valid/ready stream.
import conv_out_streamer_pkg::*;

module conv_out_streamer #(
  parameter int DATA_W = CONV_DATA_W,
  parameter int OUT_H  = CONV_OUT_H,
  parameter int OUT_W  = CONV_OUT_W,
  parameter int OUT_C  = CONV_OUT_C
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_vld,
  input  logic [OUT_C*OUT_H*OUT_W*DATA_W-1:0] conv_lin,
  output logic                              in_rdy,
  output logic                              ovf,
  conv_out_streamer_if.master               m_if
);
  localparam int FRAME_N = OUT_C * OUT_H * OUT_W;
  localparam int IDX_W   = idx_bits(FRAME_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_N - 1);

  strm_state_e                    state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [FRAME_N-1:0][DATA_W-1:0] frame_q;
  logic                           ovf_q;
  logic                           load;
  logic                           last;

  assign in_rdy      = (state_q == IDLE);
  assign m_if.m_vld  = (state_q == STREAM);
  assign last        = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign m_if.m_last = last;
  assign ovf         = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (in_vld) begin
        load    = 1'b1;
        idx_d   = '0;
        state_d = STREAM;
      end
      STREAM: if (m_if.m_ready) begin
        // final beat leaves idx parked; the next capture rezeroes it
        if (last) state_d = IDLE;
        else      idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      idx_q <= idx_d;
      if (in_vld && !in_rdy) ovf_q <= 1'b1;
      if (load) frame_q <= conv_lin;
    end
  end

  conv_stream_mux #(.DATA_W(DATA_W), .FRAME_N(FRAME_N), .IDX_W(IDX_W)) u_mux (
    .frame (frame_q),
    .idx   (idx_q),
    .data  (m_if.m_data)
  );
endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench: frames are scored into a queue when offered and checked beat by beat.
module tb_conv_out_streamer;
  localparam int DW = 8;
  localparam int N  = 108;

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vld;
  logic [N*DW-1:0] conv_lin;
  logic            in_rdy;
  logic            ovf;
  exp_t            sb[$];
  int              nvec = 0;
  int              nerr = 0;

  conv_out_streamer_if #(.DATA_W(DW)) s_if ();

  conv_out_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .conv_lin (conv_lin),
    .in_rdy   (in_rdy),
    .ovf      (ovf),
    .m_if     (s_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a frame; when accepted the scoreboard receives all N elements in stream order.
  task automatic send_frame(input logic [N*DW-1:0] f);
    exp_t e;
    chk("pre_in_rdy", in_rdy, 1);
    in_vld   = 1'b1;
    conv_lin = f;
    for (int i = 0; i < N; i++) begin
      e.d = f[i*DW +: DW];
      e.l = (i == N - 1);
      sb.push_back(e);
    end
    tick();
    in_vld   = 1'b0;
    conv_lin = '1;
    chk("latency_m_vld", s_if.m_vld, 1);
    chk("busy_in_rdy", in_rdy, 0);
  endtask

  task automatic stream(input int nbeats, input bit stall_mode);
    int   got = 0;
    int   cyc = 0;
    bit   stalled = 0;
    logic [DW-1:0] pd;
    logic pl;
    exp_t e;
    while (got < nbeats && cyc < nbeats * 4 + 8) begin
      s_if.m_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
      chk("m_vld", s_if.m_vld, 1);
      if (stalled) begin
        chk("hold_data", s_if.m_data, pd);
        chk("hold_last", s_if.m_last, pl);
      end
      if (s_if.m_ready) begin
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $error("FAIL sb_underflow observed=beat expected=none");
        end else begin
          e = sb.pop_front();
          chk("beat_data", s_if.m_data, e.d);
          chk("beat_last", s_if.m_last, e.l);
        end
        got++;
        stalled = 0;
      end else begin
        pd = s_if.m_data;
        pl = s_if.m_last;
        stalled = 1;
      end
      cyc++;
      tick();
    end
    if (got < nbeats) begin
      nvec++; nerr++;
      $error("FAIL stream_timeout observed=%0d expected=%0d", got, nbeats);
    end
    s_if.m_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_rdy"}, in_rdy, 1);
    chk({tag, "_m_vld"}, s_if.m_vld, 0);
    chk({tag, "_m_last"}, s_if.m_last, 0);
  endtask

  logic [N*DW-1:0] ramp, spot, other;
  exp_t e0;

  initial begin
    for (int i = 0; i < N; i++) begin
      ramp[i*DW +: DW]  = DW'(i % 256);
      spot[i*DW +: DW]  = '0;
      other[i*DW +: DW] = DW'(8'hFF - i);
    end
    spot[(2*36 + 5*6 + 5)*DW +: DW] = 8'hA5;

    rst = 1'b1; in_vld = 1'b0; conv_lin = '0; s_if.m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_ovf", ovf, 0);
    chk("reset_m_data", s_if.m_data, 0);
    tick();
    chk_idle("idle_hold");

    // ramp, ready always high
    send_frame(ramp);
    stream(N, 1'b0);
    chk_idle("ramp_end");
    chk("ramp_sb_empty", sb.size(), 0);

    // ramp with stalls
    send_frame(ramp);
    stream(N, 1'b1);
    chk_idle("stall_end");

    // single marked element lands on the final beat
    send_frame(spot);
    stream(N, 1'b0);
    chk_idle("spot_end");
    chk("spot_ovf", ovf, 0);

    // overlapping offer at beat 40 is dropped and flagged
    send_frame(ramp);
    stream(40, 1'b0);
    in_vld = 1'b1; conv_lin = other;
    tick();
    in_vld = 1'b0;
    chk("ovr_ovf", ovf, 1);
    stream(N - 40, 1'b0);
    chk_idle("ovr_end");
    chk("ovr_ovf_sticky", ovf, 1);
    tick(); tick();
    chk("ovr_ovf_sticky2", ovf, 1);

    // reset mid-frame aborts it
    send_frame(ramp);
    stream(50, 1'b0);
    rst = 1'b1; s_if.m_ready = 1'b1; in_vld = 1'b1; conv_lin = other;
    tick();
    rst = 1'b0; s_if.m_ready = 1'b0; in_vld = 1'b0;
    sb.delete();
    chk_idle("abort");
    chk("abort_ovf", ovf, 0);
    chk("abort_m_data", s_if.m_data, 0);
    tick();
    chk("abort_no_beats", s_if.m_vld, 0);
    send_frame(ramp);
    stream(N, 1'b0);
    chk_idle("restart_end");

    // offer coincides with the final transfer
    send_frame(ramp);
    stream(N - 1, 1'b0);
    s_if.m_ready = 1'b1; in_vld = 1'b1; conv_lin = other;
    e0 = sb.pop_front();
    chk("final_data", s_if.m_data, e0.d);
    chk("final_last", s_if.m_last, 1);
    tick();
    s_if.m_ready = 1'b0; in_vld = 1'b0;
    chk_idle("final_idle");
    chk("final_ovf", ovf, 1);
    tick();
    chk("final_dropped", s_if.m_vld, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/conv_out_streamer.md
CONV_OUT_STREAMER -- requirements
Module: conv_out_streamer

Interface
REQ-001 Parameter DATA_W, default 8, bit width of one conv result element.
REQ-002 Parameter OUT_H, default 6, rows per output channel.
REQ-003 Parameter OUT_W, default 6, columns per output channel.
REQ-004 Parameter OUT_C, default 3, number of output channels.
REQ-005 Port clk  input  1  single clock; all logic on rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port in_vld  input  1  one-cycle pulse: conv_lin holds a complete result frame.
REQ-008 Port conv_lin  input  OUT_C*OUT_H*OUT_W*DATA_W  result frame; element (c,r,k) at bit offset ((c*OUT_H*OUT_W + r*OUT_W + k)*DATA_W).
REQ-009 Port in_rdy  output  1  high when a new frame can be accepted.
REQ-010 Port m_data  output  DATA_W  current stream element.
REQ-011 Port m_vld  output  1  m_data valid.
REQ-012 Port m_ready  input  1  downstream accepts the current element.
REQ-013 Port m_last  output  1  current element is the final element of the frame.
REQ-014 Port ovf  output  1  sticky flag: a frame was offered while in_rdy was low.

Function
REQ-015 States: IDLE and STREAM; state is held in a register.
REQ-016 IDLE: in_rdy=1, m_vld=0; in_vld=1 captures conv_lin into the frame buffer, clears idx to 0, and moves to STREAM.
REQ-017 Latency: m_vld rises on the cycle after the capturing in_vld edge.
REQ-018 STREAM: in_rdy=0, m_vld=1, m_data=buffer element idx; order is channel-major, then row, then column (idx=c*OUT_H*OUT_W + r*OUT_W + k).
REQ-019 Handshake: a beat transfers on a clock edge where m_vld and m_ready are both 1; idx increments by 1 only on a transfer.
REQ-020 m_data and m_last hold stable while m_vld=1 and m_ready=0; m_vld is never withdrawn before a transfer.
REQ-021 m_last=1 exactly when STREAM and idx=OUT_C*OUT_H*OUT_W-1 (107 at defaults); otherwise m_last=0.
REQ-022 A transfer with m_last=1 returns the block to IDLE; idx does not wrap inside STREAM.
REQ-023 in_vld while in_rdy=0 (including the cycle of the last transfer) is ignored for data and sets ovf=1; the buffer is not modified.
REQ-024 ovf remains set until reset.
REQ-025 idx width is clog2(OUT_C*OUT_H*OUT_W); 7 bits at defaults.
REQ-026 The frame buffer is written only on an accepted in_vld; m_data passes buffer contents through with no arithmetic or sign change.

Reset
REQ-027 rst=1 at a clock edge forces IDLE, idx=0, ovf=0, in_rdy=1, m_vld=0, m_last=0.
REQ-028 m_data is 0 after reset; the frame buffer is cleared to 0.
REQ-029 Reset during STREAM aborts the frame; no further beats are issued, and the next in_vld after reset release starts a fresh frame at idx 0.
REQ-030 rst takes priority over in_vld and m_ready in the same cycle.

Structure
REQ-031 OUT_H, OUT_W, OUT_C, DATA_W defaults and the frame element count are shared constants in the project's common header, also used by the conv block.
REQ-032 One sub-module is natural: conv_stream_mux (combinational idx -> DATA_W element select from the buffer); the rest is a single module.

Verification
REQ-033 Ramp frame (element i = i mod 256), m_ready held 1 -> m_vld rises 1 cycle after in_vld; 108 beats with m_data 0..107 in order; m_last only on beat 107; in_rdy=1 on the following cycle.
REQ-034 Same frame, m_ready toggling 1,0,0,1,... -> 108 transfers with data unchanged during stalls; m_data/m_last stable while m_ready=0.
REQ-035 Frame where channel 2, row 5, col 5 = 0xA5 and all other elements = 0 -> only beat 107 carries 0xA5, together with m_last=1.
REQ-036 Second in_vld at beat 40 with a different frame -> stream continues with the original data; ovf=1 and stays set.
REQ-037 rst pulsed at beat 50 -> next cycle m_vld=0, in_rdy=1, ovf=0; a new in_vld restarts at beat 0.
REQ-038 in_vld in the same cycle as the last transfer -> frame dropped, ovf=1, state returns to IDLE.
